// File: rtl/fifo_seg_drain.sv
// fifo_seg_drain: pops FIFO bytes one at a time into a 4-byte shift register shown on eight 7-segment digits
module fifo_seg_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_CYCLES = 4,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1,
  output logic [7:0]            seg2,
  output logic [7:0]            seg3,
  output logic [7:0]            seg4,
  output logic [7:0]            seg5,
  output logic [7:0]            seg6,
  output logic [7:0]            seg7,
  output logic [7:0]            byte_cnt,
  output logic                  busy
);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int HLOAD = HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0;
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] disp_buf;
  logic [HW-1:0] hold_cnt;
  logic [7:0] seg [8];
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      disp_buf <= '0;
      hold_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == CAPTURE) begin
        disp_buf <= {disp_buf[23:0], fifo_rd_data[7:0]};
        byte_cnt <= byte_cnt + 8'd1;
        hold_cnt <= HW'(HLOAD);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (fifo_empty ? IDLE : CAPTURE)
             : state == CAPTURE ? (HOLD_CYCLES == 0 ? IDLE : HOLD)
             : hold_cnt == '0 ? IDLE : HOLD;
    fifo_rd_en = state == IDLE && !fifo_empty && !rst;
    busy = state != IDLE;
  end
  // only the least significant digit's dp carries the busy indication
  for (genvar k = 0; k < 8; k++) begin : g_seg
    logic [7:0] raw;
    assign raw = {k == 0 ? busy : 1'b0, hex7(disp_buf[4*k +: 4])};
    assign seg[k] = SEG_ACTIVE_LOW ? ~raw : raw;
  end
  assign seg0 = seg[0];
  assign seg1 = seg[1];
  assign seg2 = seg[2];
  assign seg3 = seg[3];
  assign seg4 = seg[4];
  assign seg5 = seg[5];
  assign seg6 = seg[6];
  assign seg7 = seg[7];
endmodule
